// File: rtl/gate_bank_checker.sv
// gate_bank_checker
//   Self-checking stimulus/response engine for the two-input primitive gate
//   bank (inv, and2, or2, xor2, nand2, nor2). It walks {a,b} through 00, 01,
//   10 and 11. For each vector it waits SETTLE_CYCLES, samples the six gate
//   outputs and compares them with the truth table. It then reports a sticky
//   per-gate mismatch mask, a saturating error count and a pass verdict.
//
//   Optional feature macro: GATE_CHECKER_FIRST_FAIL_EN
//     Adds first_fail_ab / first_fail_obs, which hold the index and the
//     observed outputs of the first failing vector of a run.
//
//   Ports:
//     clk            rising-edge clock
//     rst_n          asynchronous active-low reset
//     start          begin a run (sampled only in IDLE)
//     dut_a, dut_b   registered stimulus to gate inputs a / b
//     dut_out[5:0]   observed {inv,and,or,xor,nand,nor}
//     busy           high from the start edge until DONE
//     done           one-cycle pulse at the end of a run
//     pass           verdict of the last completed run
//     err_count      number of failing vectors, saturating
//     fail_vec[5:0]  sticky per-gate mismatch mask
module gate_bank_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic [5:0]       dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  output logic [5:0]       fail_vec,
  output logic [1:0]       first_fail_ab,
  output logic [5:0]       first_fail_obs
`else
  output logic [5:0]       fail_vec
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [5:0]       fail_q, fail_d;
  logic [5:0]       exp_vec;
  logic [5:0]       mism;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic [1:0]       ff_ab_q, ff_ab_d;
  logic [5:0]       ff_obs_q, ff_obs_d;
`endif

  // Expected {inv,and,or,xor,nand,nor} for the applied vector
  always_comb begin
    unique case (idx_q)
      2'b00:   exp_vec = 6'b100011;
      2'b01:   exp_vec = 6'b101110;
      2'b10:   exp_vec = 6'b001110;
      default: exp_vec = 6'b011000;
    endcase
    mism = dut_out ^ exp_vec;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE;
      S_DRIVE:  state_d = S_SETTLE;
      // Leaving on count==1 gives exactly SETTLE_CYCLES cycles in SETTLE
      S_SETTLE: if (cnt_q <= 8'd1) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (idx_q == 2'd3) ? S_DONE : S_DRIVE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    err_d  = err_q;
    fail_d = fail_q;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    ff_ab_d  = ff_ab_q;
    ff_obs_d = ff_obs_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d  = 2'd0;
          busy_d = 1'b1;
          pass_d = 1'b0;
          err_d  = '0;
          fail_d = '0;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
          ff_ab_d  = '0;
          ff_obs_d = '0;
`endif
        end
      end
      S_DRIVE: begin
        a_d   = idx_q[1];
        b_d   = idx_q[0];
        cnt_d = SETTLE_CYCLES[7:0];
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 8'd1;
      end
      S_SAMPLE: begin
        fail_d = fail_q | mism;
        if (mism != '0) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
          // err_count is still zero only before the first failing vector
          if (err_q == '0) begin
            ff_ab_d  = idx_q;
            ff_obs_d = dut_out;
          end
`endif
        end
        if (idx_q == 2'd3) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          a_d    = 1'b0;
          b_d    = 1'b0;
          pass_d = ((fail_q | mism) == '0);
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      fail_q <= '0;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
      ff_ab_q  <= '0;
      ff_obs_q <= '0;
`endif
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      fail_q <= fail_d;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
      ff_ab_q  <= ff_ab_d;
      ff_obs_q <= ff_obs_d;
`endif
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  assign first_fail_ab  = ff_ab_q;
  assign first_fail_obs = ff_obs_q;
`endif

endmodule

// File: tb/tb_gate_bank_checker.sv
// Directed testbench for gate_bank_checker. Two instances share clk, rst_n
// and start: u_dut0 (ERR_W=3) and u_dut1 (ERR_W=1). Each instance drives its
// own behavioural gate bank, which has injectable faults (invert / stuck-at-0
// / stuck-at-1 masks).
module tb_gate_bank_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [5:0] inv0, sa0_0, sa1_0;
  logic [5:0] inv1, sa0_1, sa1_1;

  logic       a0, b0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [5:0] fail0, out0;
  logic       a1, b1, busy1, done1, pass1;
  logic [0:0] err1;
  logic [5:0] fail1, out1;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic [1:0] ffab0, ffab1;
  logic [5:0] ffobs0, ffobs1;
`endif

  int vectors    = 0;
  int miscompares = 0;

  function automatic logic [5:0] bank(input logic a, input logic b,
                                      input logic [5:0] inv,
                                      input logic [5:0] sa0,
                                      input logic [5:0] sa1);
    logic [5:0] g;
    g = {~a, a & b, a | b, a ^ b, ~(a & b), ~(a | b)};
    return ((g ^ inv) & ~sa0) | sa1;
  endfunction

  assign out0 = bank(a0, b0, inv0, sa0_0, sa1_0);
  assign out1 = bank(a1, b1, inv1, sa0_1, sa1_1);

  gate_bank_checker #(.SETTLE_CYCLES(2), .ERR_W(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(a0), .dut_b(b0), .dut_out(out0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0),
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    .fail_vec(fail0), .first_fail_ab(ffab0), .first_fail_obs(ffobs0)
`else
    .fail_vec(fail0)
`endif
  );

  gate_bank_checker #(.SETTLE_CYCLES(2), .ERR_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(a1), .dut_b(b1), .dut_out(out1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1),
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    .fail_vec(fail1), .first_fail_ab(ffab1), .first_fail_obs(ffobs1)
`else
    .fail_vec(fail1)
`endif
  );

  // Start one run. Edge 0 is the edge that samples start. Reports the edge
  // after which done0 was seen (-1 if never), the {a,b} pairs seen in each
  // SAMPLE cycle, and busy0 mid-run. The repulse edge re-asserts start
  // while the run is busy.
  task automatic do_run(input int repulse_edge, output int done_edge,
                        output logic [7:0] ab_log, output logic busy_mid);
    done_edge = -1;
    ab_log    = '0;
    busy_mid  = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int n = 1; n <= 40 && done_edge < 0; n++) begin
      if (n == repulse_edge) begin
        @(negedge clk); start = 1'b1;
      end
      @(posedge clk); #1;
      if (n == repulse_edge) start = 1'b0;
      if ((n % 4) == 3 && n <= 15) ab_log = {ab_log[5:0], a0, b0};
      if (n == 8) busy_mid = busy0;
      if (done0) done_edge = n;
    end
  endtask

  task automatic set_faults(input logic [5:0] i0, input logic [5:0] z0,
                            input logic [5:0] o0, input logic [5:0] i1);
    @(negedge clk);
    inv0 = i0; sa0_0 = z0; sa1_0 = o0;
    inv1 = i1; sa0_1 = '0; sa1_1 = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({a0, b0, busy0, done0, pass0, err0, fail0} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected 0",
               {a0, b0, busy0, done0, pass0, err0, fail0});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_good_bank;
    int de; logic [7:0] ab; logic bm;
    set_faults('0, '0, '0, '0);
    do_run(0, de, ab, bm);
    vectors++; if (de !== 16) begin miscompares++;
      $display("FAIL good_done_edge: got %0d expected 16", de); end
    vectors++; if (ab !== 8'b00_01_10_11) begin miscompares++;
      $display("FAIL good_ab_seq: got %b expected 00011011", ab); end
    vectors++; if (bm !== 1'b1) begin miscompares++;
      $display("FAIL good_busy_mid: got %b expected 1", bm); end
    vectors++; if ({busy0, pass0, err0, fail0} !== {1'b0, 1'b1, 3'd0, 6'd0}) begin
      miscompares++;
      $display("FAIL good_result: busy/pass/err/fail got %b/%b/%0d/%b expected 0/1/0/000000",
               busy0, pass0, err0, fail0); end
    vectors++; if ({a0, b0} !== 2'b00) begin miscompares++;
      $display("FAIL good_ab_done: got %b%b expected 00", a0, b0); end
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    vectors++; if ({ffab0, ffobs0} !== 8'd0) begin miscompares++;
      $display("FAIL good_first_fail: got %b/%b expected 00/000000", ffab0, ffobs0); end
`endif
    @(posedge clk); #1;
    vectors++; if ({done0, pass0} !== 2'b01) begin miscompares++;
      $display("FAIL good_after_done: done/pass got %b/%b expected 0/1", done0, pass0); end
  endtask

  task automatic test_xor_stuck0;
    int de; logic [7:0] ab; logic bm;
    set_faults('0, 6'b000100, '0, '0);
    // start re-pulsed at edge 5 while busy must be ignored
    do_run(5, de, ab, bm);
    vectors++; if (de !== 16) begin miscompares++;
      $display("FAIL xor_done_edge: got %0d expected 16", de); end
    vectors++; if ({pass0, err0, fail0} !== {1'b0, 3'd2, 6'b000100}) begin
      miscompares++;
      $display("FAIL xor_result: pass/err/fail got %b/%0d/%b expected 0/2/000100",
               pass0, err0, fail0); end
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    vectors++; if ({ffab0, ffobs0} !== {2'b01, 6'b101010}) begin miscompares++;
      $display("FAIL xor_first_fail: got %b/%b expected 01/101010", ffab0, ffobs0); end
`endif
    @(posedge clk); #1;
    vectors++; if ({done0, busy0} !== 2'b00) begin miscompares++;
      $display("FAIL xor_idle_after: done/busy got %b/%b expected 0/0", done0, busy0); end
  endtask

  task automatic test_inv_nor;
    int de; logic [7:0] ab; logic bm;
    set_faults('0, 6'b000001, 6'b100000, '0);
    do_run(0, de, ab, bm);
    vectors++; if (de !== 16) begin miscompares++;
      $display("FAIL invnor_done_edge: got %0d expected 16", de); end
    vectors++; if ({pass0, err0, fail0} !== {1'b0, 3'd3, 6'b100001}) begin
      miscompares++;
      $display("FAIL invnor_result: pass/err/fail got %b/%0d/%b expected 0/3/100001",
               pass0, err0, fail0); end
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    vectors++; if ({ffab0, ffobs0} !== {2'b00, 6'b100010}) begin miscompares++;
      $display("FAIL invnor_first_fail: got %b/%b expected 00/100010", ffab0, ffobs0); end
`endif
  endtask

  task automatic test_saturate;
    int de; logic [7:0] ab; logic bm;
    set_faults('0, '0, '0, 6'b111111);
    do_run(0, de, ab, bm);
    vectors++; if ({done1, pass1, err1, fail1} !== {1'b1, 1'b0, 1'b1, 6'b111111}) begin
      miscompares++;
      $display("FAIL sat_result: done/pass/err/fail got %b/%b/%0d/%b expected 1/0/1/111111",
               done1, pass1, err1, fail1); end
    vectors++; if ({pass0, err0, fail0} !== {1'b1, 3'd0, 6'd0}) begin miscompares++;
      $display("FAIL sat_clean_inst: pass/err/fail got %b/%0d/%b expected 1/0/000000",
               pass0, err0, fail0); end
  endtask

  task automatic test_midrun_reset;
    int de; int saw_done; logic [7:0] ab; logic bm;
    set_faults('0, '0, '0, '0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vectors++; if ({a0, b0, busy0} !== 3'b101) begin miscompares++;
      $display("FAIL rst_pre_state: a/b/busy got %b%b/%b expected 10/1", a0, b0, busy0); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({a0, b0, busy0, done0, pass0, err0, fail0} !== 15'd0) begin
      miscompares++;
      $display("FAIL rst_midrun: got %b expected 0",
               {a0, b0, busy0, done0, pass0, err0, fail0}); end
    @(negedge clk); rst_n = 1'b1;
    saw_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done0 || busy0) saw_done++;
    end
    vectors++; if (saw_done !== 0) begin miscompares++;
      $display("FAIL rst_no_done: got %0d active cycles expected 0", saw_done); end
    do_run(0, de, ab, bm);
    vectors++; if (de !== 16 || pass0 !== 1'b1) begin miscompares++;
      $display("FAIL rst_rerun: done_edge/pass got %0d/%b expected 16/1", de, pass0); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    inv0 = '0; sa0_0 = '0; sa1_0 = '0;
    inv1 = '0; sa0_1 = '0; sa1_1 = '0;
    test_reset;
    test_good_bank;
    test_xor_stuck0;
    test_inv_nor;
    test_saturate;
    test_midrun_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
